csr_trap_unit: RTL and testbench
================================

// Module: csr_trap_unit
// PURPOSE
// - M-mode CSR file and trap sequencer.
// - Consumes the instruction decoder's CSR controls (write/set/clear), IllegalInstruction and MRET,
//   plus external/timer interrupt lines. Produces CSR read data, trap/return PC redirect and pipeline flush.
// - Sits beside the EX stage: the decoder flags the event, this block commits state and steers the PC.
// PARAMETERS
// - MTVEC_RESET  32'h0000_0100  mtvec reset value.
// - VECTORED_EN  1              1: mtvec mode bit writable (vectored interrupts); 0: mode forced direct.
// - MISA_VALUE   32'h4000_0100  read-only misa (RV32I).
// PORTS
// - clk           in   1   clock, rising edge
// - rst           in   1   synchronous, active-high reset
// - instr_valid   in   1   EX-stage instruction valid this cycle
// - instr_pc      in   32  PC of EX-stage instruction
// - instr_bits    in   32  raw instruction word; captured into mtval on illegal instruction
// - illegal_instr in   1   decoder IllegalInstruction
// - mret          in   1   decoder MRET
// - csr_write     in   1   CSRRW/CSRRWI
// - csr_set       in   1   CSRRS/CSRRSI
// - csr_clear     in   1   CSRRC/CSRRCI
// - csr_addr      in   12  CSR address (instr[31:20])
// - csr_wdata     in   32  rs1 value or zero-extended uimm
// - csr_rdata     out  32  combinational, pre-update value of csr_addr
// - instr_retire  in   1   one instruction retired this cycle
// - ext_irq       in   1   level machine external interrupt (mip.MEIP)
// - timer_irq     in   1   level machine timer interrupt (mip.MTIP)
// - redirect_valid out 1   registered; PC must load redirect_pc this cycle
// - redirect_pc   out  32  trap vector or mepc
// - flush         out  1   registered; equals redirect_valid; kills IF/ID/EX
// BEHAVIOUR
// - Reset: redirect_valid=0, redirect_pc=0, flush=0, state=RUN.
//   CSRs: mstatus=0, mie=0, mtvec=MTVEC_RESET, mscratch/mepc/mcause/mtval=0, mcycle=minstret=0.
// - CSR map:
//   - mstatus 0x300: MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0.
//   - misa 0x301: RO.
//   - mie 0x304: MTIE[7], MEIE[11].
//   - mtvec 0x305: bit1 reads 0; bit0 reads 0 if !VECTORED_EN.
//   - mscratch 0x340.
//   - mepc 0x341: [1:0] read 0.
//   - mcause 0x342, mtval 0x343.
//   - mip 0x344: RO, reflects irq inputs.
//   - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
//   - Unmapped addresses read 0; writes to them are dropped.
// - Update rule (needs instr_valid, state RUN, no trap, no mret):
//   - write: new=wdata. set: new=old|wdata. clear: new=old&~wdata.
//   - Priority write>set>clear if several are asserted. Writes to RO CSRs are dropped.
// - irq_pend = mstatus.MIE & ((ext_irq&mie.MEIE) | (timer_irq&mie.MTIE)).
// - FSM: RUN, REDIRECT.
//   - RUN, instr_valid & (irq_pend | illegal_instr) -> REDIRECT. On that edge:
//     - mepc<=instr_pc; MPIE<=MIE; MIE<=0.
//     - Cause priority MEI(0x8000000B) > MTI(0x80000007) > illegal(2).
//     - mtval<=instr_bits for illegal, else 0.
//     - redirect_pc = mtvec base, or base+4*code when vectored and the cause is an interrupt.
//   - RUN, instr_valid & mret & !irq_pend -> REDIRECT. On that edge: MIE<=MPIE, MPIE<=1, redirect_pc<=mepc.
//   - REDIRECT -> RUN unconditionally. redirect_valid=flush=1 for exactly this one cycle.
//   - All inputs are ignored in REDIRECT (the instruction is being flushed).
// - Latency: event at cycle T -> redirect_valid at T+1 -> target PC fetched at T+2.
// - mret asserts csr_clear in the decoder encoding; csr ops are suppressed whenever mret or a trap is taken.
// - Counters:
//   - mcycle +1 every cycle. minstret +1 on instr_retire (suppressed in REDIRECT).
//   - 64-bit, wrap to 0.
//   - A CSR write to either half replaces that half; the increment is skipped that cycle.
// - rst mid-REDIRECT: next state RUN, redirect_valid=0, all CSRs to reset values.
// STRUCTURE
// - Shared package csr_pkg:
//   - CSR address localparams.
//   - mcause codes.
//   - mstatus/mie/mip bit indices.
//   - FSM state encoding (RUN=1'b0, REDIRECT=1'b1).
// - One sub-module csr_counter64: 64-bit counter with increment enable and per-half write port;
//   instantiated for mcycle and minstret.
// TESTING
// - CSRRW 0x340 wdata=0xDEADBEEF, then CSRRS wdata=0x1 -> rdata 0 then 0xDEADBEEF; mscratch ends 0xDEADBEEF.
// - Illegal instr at pc=0x40, bits=0xFFFFFFFF, MIE=1 -> T+1:
//   redirect_valid=1, redirect_pc=0x100, mepc=0x40, mcause=2, mtval=0xFFFFFFFF, MIE=0, MPIE=1.
// - mret after the previous case with mepc=0x44 -> T+1: redirect_pc=0x44, MIE=1, MPIE=1; mscratch unchanged despite csr_clear=1.
// - mtvec=0x201 (vectored), MIE=1, MEIE=1, ext_irq=1 together with illegal instr ->
//   mcause=0x8000000B, redirect_pc=0x22C.
// - Write mcycle=0xFFFFFFFF, mcycleh=0 -> two cycles later mcycleh=1, mcycle=0 (increment skipped on write cycle).
// - rst during REDIRECT -> next cycle redirect_valid=0, mtvec=0x100, mepc=0.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, trap causes, bit indices and FSM encoding
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MTI      = 7;
  localparam int IRQ_MEI      = 11;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with increment enable and per-half write port
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // A software write to either half wins over the increment for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc_en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - M-mode CSR file and trap/return sequencer beside the EX stage
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr_pc,
  input  logic [31:0] instr_bits,
  input  logic        illegal_instr,
  input  logic        mret,
  input  logic        csr_write,
  input  logic        csr_set,
  input  logic        csr_clear,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        instr_retire,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  state_t      state;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_meie, mie_mtie;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle, minstret;

  logic        in_run, irq_ext, irq_tmr, irq_pend;
  logic        take_trap, take_mret, csr_en;
  logic [31:0] trap_cause, trap_target, mtvec_rd, mepc_rd, mtvec_base, csr_new;

  assign in_run   = (state == RUN);
  assign irq_ext  = ext_irq   & mie_meie & mstatus_mie;
  assign irq_tmr  = timer_irq & mie_mtie & mstatus_mie;
  assign irq_pend = irq_ext | irq_tmr;

  assign take_trap = in_run & instr_valid & (irq_pend | illegal_instr);
  assign take_mret = in_run & instr_valid & mret & ~take_trap;
  // mret rides on a csr_clear encoding, so any mret suppresses the CSR op.
  assign csr_en    = in_run & instr_valid & ~take_trap & ~mret &
                     (csr_write | csr_set | csr_clear);

  assign mtvec_rd   = mtvec_q & MTVEC_MASK;
  assign mepc_rd    = mepc_q & 32'hFFFF_FFFC;
  assign mtvec_base = mtvec_rd & 32'hFFFF_FFFC;

  assign trap_cause  = irq_ext ? CAUSE_MEI : (irq_tmr ? CAUSE_MTI : CAUSE_ILLEGAL);
  assign trap_target = (mtvec_rd[0] && trap_cause[31]) ?
                       mtvec_base + {25'd0, trap_cause[4:0], 2'b00} : mtvec_base;

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[12:11]        = 2'b11;
        csr_rdata[MSTATUS_MPIE] = mstatus_mpie;
        csr_rdata[MSTATUS_MIE]  = mstatus_mie;
      end
      CSR_MISA:      csr_rdata = MISA_VALUE;
      CSR_MIE: begin
        csr_rdata[IRQ_MEI] = mie_meie;
        csr_rdata[IRQ_MTI] = mie_mtie;
      end
      CSR_MTVEC:     csr_rdata = mtvec_rd;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_rd;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP: begin
        csr_rdata[IRQ_MEI] = ext_irq;
        csr_rdata[IRQ_MTI] = timer_irq;
      end
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      default:       csr_rdata = 32'd0;
    endcase
  end

  assign csr_new = csr_write ? csr_wdata :
                   csr_set   ? (csr_rdata | csr_wdata) :
                               (csr_rdata & ~csr_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= 32'd0;
      mepc_q       <= 32'd0;
      mcause_q     <= 32'd0;
      mtval_q      <= 32'd0;
    end else if (take_trap) begin
      mepc_q       <= instr_pc;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mcause_q     <= trap_cause;
      mtval_q      <= irq_pend ? 32'd0 : instr_bits;
    end else if (take_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= csr_new[MSTATUS_MIE];
          mstatus_mpie <= csr_new[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          mie_meie <= csr_new[IRQ_MEI];
          mie_mtie <= csr_new[IRQ_MTI];
        end
        CSR_MTVEC:    mtvec_q    <= csr_new;
        CSR_MSCRATCH: mscratch_q <= csr_new;
        CSR_MEPC:     mepc_q     <= csr_new;
        CSR_MCAUSE:   mcause_q   <= csr_new;
        CSR_MTVAL:    mtval_q    <= csr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (take_trap) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_target;
          end else if (take_mret) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc_rd;
          end else begin
            redirect_valid <= 1'b0;
          end
        end
        REDIRECT: begin
          state          <= RUN;
          redirect_valid <= 1'b0;
        end
        default: begin
          state          <= RUN;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  assign flush = redirect_valid;

  csr_counter64 u_mcycle (
    .clk    (clk),
    .rst    (rst),
    .inc_en (1'b1),
    .wr_lo  (csr_en && csr_addr == CSR_MCYCLE),
    .wr_hi  (csr_en && csr_addr == CSR_MCYCLEH),
    .wdata  (csr_new),
    .count  (mcycle)
  );

  csr_counter64 u_minstret (
    .clk    (clk),
    .rst    (rst),
    .inc_en (instr_retire & in_run),
    .wr_lo  (csr_en && csr_addr == CSR_MINSTRET),
    .wr_hi  (csr_en && csr_addr == CSR_MINSTRETH),
    .wdata  (csr_new),
    .count  (minstret)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed self-checking bench for csr_trap_unit
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_bits;
  logic        illegal_instr;
  logic        mret;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clear;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        instr_retire;
  logic        ext_irq;
  logic        timer_irq;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_trap_unit dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .instr_bits     (instr_bits),
    .illegal_instr  (illegal_instr),
    .mret           (mret),
    .csr_write      (csr_write),
    .csr_set        (csr_set),
    .csr_clear      (csr_clear),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .instr_retire   (instr_retire),
    .ext_irq        (ext_irq),
    .timer_irq      (timer_irq),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid   = 1'b0;
    instr_pc      = 32'd0;
    instr_bits    = 32'd0;
    illegal_instr = 1'b0;
    mret          = 1'b0;
    csr_write     = 1'b0;
    csr_set       = 1'b0;
    csr_clear     = 1'b0;
    csr_addr      = 12'd0;
    csr_wdata     = 32'd0;
    instr_retire  = 1'b0;
  endtask

  task automatic csrrw(input logic [11:0] a, input logic [31:0] d);
    idle();
    instr_valid = 1'b1;
    csr_write   = 1'b1;
    csr_addr    = a;
    csr_wdata   = d;
  endtask

  initial begin
    rst       = 1'b1;
    ext_irq   = 1'b0;
    timer_irq = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_flush", {31'd0, flush}, 32'd0);
    rd(12'h305, "reset_mtvec", 32'h0000_0100);
    rd(12'h300, "reset_mstatus", 32'h0000_1800);
    rd(12'h301, "misa", 32'h4000_0100);

    // CSRRW then CSRRS on mscratch
    csrrw(12'h340, 32'hDEAD_BEEF);
    #1;
    check("csrrw_old_rdata", csr_rdata, 32'd0);
    tick();
    csr_write = 1'b0;
    csr_set   = 1'b1;
    csr_wdata = 32'h0000_0001;
    #1;
    check("csrrs_old_rdata", csr_rdata, 32'hDEAD_BEEF);
    tick();
    idle();
    rd(12'h340, "mscratch_final", 32'hDEAD_BEEF);

    // RO and unmapped writes are dropped
    csrrw(12'h301, 32'd0);
    tick();
    csrrw(12'h7C0, 32'h1234_5678);
    tick();
    idle();
    rd(12'h301, "misa_ro", 32'h4000_0100);
    rd(12'h7C0, "unmapped_zero", 32'd0);

    // Enable MIE
    csrrw(12'h300, 32'h0000_0008);
    tick();
    idle();
    rd(12'h300, "mstatus_mie_set", 32'h0000_1808);

    // Illegal instruction trap
    idle();
    instr_valid   = 1'b1;
    illegal_instr = 1'b1;
    instr_pc      = 32'h0000_0040;
    instr_bits    = 32'hFFFF_FFFF;
    tick();
    idle();
    check("ill_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("ill_flush", {31'd0, flush}, 32'd1);
    check("ill_redirect_pc", redirect_pc, 32'h0000_0100);
    rd(12'h341, "ill_mepc", 32'h0000_0040);
    rd(12'h342, "ill_mcause", 32'h0000_0002);
    rd(12'h343, "ill_mtval", 32'hFFFF_FFFF);
    rd(12'h300, "ill_mstatus", 32'h0000_1880);
    tick();
    check("ill_redirect_drop", {31'd0, redirect_valid}, 32'd0);

    // mret with csr_clear also asserted
    csrrw(12'h341, 32'h0000_0044);
    tick();
    idle();
    instr_valid = 1'b1;
    mret        = 1'b1;
    csr_clear   = 1'b1;
    csr_addr    = 12'h340;
    csr_wdata   = 32'hFFFF_FFFF;
    tick();
    idle();
    check("mret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("mret_redirect_pc", redirect_pc, 32'h0000_0044);
    rd(12'h300, "mret_mstatus", 32'h0000_1888);
    rd(12'h340, "mret_mscratch", 32'hDEAD_BEEF);
    // A CSR write presented during REDIRECT must be ignored
    csrrw(12'h340, 32'h1234_5678);
    tick();
    idle();
    check("post_mret_redirect_drop", {31'd0, redirect_valid}, 32'd0);
    rd(12'h340, "redirect_ignores_csr", 32'hDEAD_BEEF);

    // Vectored external interrupt beats illegal instruction
    csrrw(12'h305, 32'h0000_0201);
    tick();
    csrrw(12'h304, 32'h0000_0800);
    tick();
    idle();
    rd(12'h305, "mtvec_vectored", 32'h0000_0201);
    ext_irq = 1'b1;
    rd(12'h344, "mip_meip", 32'h0000_0800);
    instr_valid   = 1'b1;
    illegal_instr = 1'b1;
    instr_pc      = 32'h0000_0080;
    instr_bits    = 32'hFFFF_FFFF;
    tick();
    idle();
    ext_irq = 1'b0;
    check("mei_redirect_pc", redirect_pc, 32'h0000_022C);
    rd(12'h342, "mei_mcause", 32'h8000_000B);
    rd(12'h343, "mei_mtval", 32'd0);
    rd(12'h341, "mei_mepc", 32'h0000_0080);
    tick();

    // mcycle half writes and carry
    csrrw(12'hB00, 32'hFFFF_FFFF);
    tick();
    csrrw(12'hB80, 32'd0);
    tick();
    idle();
    rd(12'hB00, "mcycle_lo_held", 32'hFFFF_FFFF);
    rd(12'hB80, "mcycle_hi_held", 32'd0);
    tick();
    rd(12'hB80, "mcycleh_carry", 32'd1);
    rd(12'hB00, "mcycle_wrap", 32'd0);

    // minstret: write cycle skips the increment even with retire high
    csrrw(12'hB02, 32'd5);
    instr_retire = 1'b1;
    tick();
    idle();
    instr_retire = 1'b1;
    tick();
    tick();
    idle();
    rd(12'hB02, "minstret_count", 32'd7);

    // Exception with vectored mtvec still goes to base; then reset mid-REDIRECT
    idle();
    instr_valid   = 1'b1;
    illegal_instr = 1'b1;
    instr_pc      = 32'h0000_0090;
    tick();
    idle();
    check("exc_vectored_base", redirect_pc, 32'h0000_0200);
    check("exc_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    rd(12'h305, "rst_mtvec", 32'h0000_0100);
    rd(12'h341, "rst_mepc", 32'd0);
    rd(12'hB00, "rst_mcycle", 32'd0);
    csrrw(12'h340, 32'h0000_00A5);
    tick();
    idle();
    rd(12'h340, "rst_state_run", 32'h0000_00A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
